// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU memory-bus hub: I/O window decode,
// UART/clock register addresses and the read-source select.
package mmio_pkg;

  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;
  localparam logic [17:0] IO_MASK = 18'h30000;

  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } hub_src_e;

  function automatic logic is_io(input logic [17:0] addr);
    return (addr & IO_MASK) == IO_MASK;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with occupancy count. A push on a full queue is accepted
// only when a pop frees the head in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign count_nxt = count_d;
  assign pop_data  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// CPU memory-bus hub: RAM/I-O decode, UART TX/RX queues, cycle counter with
// coherent snapshot, program-stop flag and one-cycle registered read return.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_done,
  output logic        tx_overflow
);

  logic [17:0] addr;
  logic        io_sel, uart_hit, clk_hit, clk_load;
  logic        tx_push, tx_pop, rx_pop;
  logic [7:0]  tx_wdata, rx_head;
  logic        tx_full, tx_empty, rx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count, tx_count_nxt;
  logic [$clog2(RX_DEPTH):0] rx_count, rx_count_nxt;
  logic        unused_ok;

  hub_src_e    src_q, src_d;
  logic [7:0]  io_rdata_q, io_rdata_d;
  logic [31:0] cnt_q, cnt_d, snap_q, snap_d;
  logic        done_q, done_d, ovf_q, ovf_d, full_q, full_d, live_q;

  assign unused_ok = ^{mem_a[31:18], rx_count, rx_count_nxt, tx_count};

  assign addr      = mem_a[17:0];
  assign io_sel    = is_io(addr);
  assign uart_hit  = (addr == IO_UART);
  assign clk_hit   = (addr[17:2] == IO_CLK[17:2]);
  assign clk_load  = (addr == IO_CLK);

  assign ram_addr  = mem_a[16:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = mem_wr & ~io_sel & cpu_rdy;

  // The stop write pushes a literal 0x00 that skips the zero filter.
  assign tx_push   = cpu_rdy & mem_wr & ((uart_hit & (mem_dout != 8'h00)) | clk_load);
  assign tx_wdata  = clk_load ? 8'h00 : mem_dout;
  assign tx_valid  = ~tx_empty;
  assign tx_pop    = tx_valid & tx_ready;
  assign rx_pop    = cpu_rdy & ~mem_wr & uart_hit;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_wdata),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .count_nxt (tx_count_nxt)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (),
    .empty     (rx_empty),
    .count     (rx_count),
    .count_nxt (rx_count_nxt)
  );

  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    snap_d = (cpu_rdy && !mem_wr && clk_load) ? cnt_q : snap_q;
    src_d  = io_sel ? SRC_IO : SRC_RAM;
    io_rdata_d = 8'h00;
    if (uart_hit) begin
      io_rdata_d = rx_empty ? 8'h00 : rx_head;
    end else if (clk_hit) begin
      io_rdata_d = snap_d[{addr[1:0], 3'b000} +: 8];
    end
    done_d = done_q | (cpu_rdy & mem_wr & clk_load);
    ovf_d  = ovf_q | (tx_push & tx_full & ~tx_pop);
    full_d = (TX_DEPTH - int'(tx_count_nxt)) <= FULL_MARGIN;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q      <= '0;
      snap_q     <= '0;
      src_q      <= SRC_RAM;
      io_rdata_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      src_q      <= src_d;
      io_rdata_q <= io_rdata_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
      live_q     <= 1'b1;
    end
  end

  // live_q keeps the read bus at zero until the first post-reset address cycle.
  assign mem_din        = !live_q ? 8'h00 : (src_q == SRC_RAM) ? ram_rdata : io_rdata_q;
  assign io_buffer_full = full_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: vector table for the single-cycle bus behaviour,
// hand sequences for queue fill/overflow, reset and counter snapshot coherence.
module tb_mmio_hub;

  logic        clk_in, rst_in, cpu_rdy, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic        program_done, tx_overflow;

  int n_vec = 0;
  int n_err = 0;

  mmio_hub dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_rdy        (cpu_rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: registered read, one cycle after the address.
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference cycle count: zero in reset, +1 on every edge after release.
  logic [31:0] tb_cnt;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tb_cnt <= 32'd0;
    else         tb_cnt <= tb_cnt + 32'd1;
  end

  // Bytes the transmitter accepts (state seen just before the accepting edge).
  logic [7:0] tx_seen [$];
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
  end

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        rdy;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        exp_we;
    logic        chk_din;
    logic [7:0]  exp_din;
    logic        exp_txv;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00; cpu_rdy = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
  endtask

  // Drive one bus cycle at posedge+1 and return at the following posedge+1.
  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic txr);
    mem_a = a; mem_wr = wr; mem_dout = d; cpu_rdy = 1'b1; tx_ready = txr;
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b0;
    #1;
    chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
    chk("rst_full", {31'h0, io_buffer_full}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_done", {31'h0, program_done}, 32'h0);
    chk("rst_ovf", {31'h0, tx_overflow}, 32'h0);
    #20;
    chk("rst_held_tx_valid", {31'h0, tx_valid}, 32'h0);
    #3 rst_in = 1'b1;
    tx_seen.delete();
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [31:0] snap;
    int          guard;

    for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;

    //            a             wr    dout   rdy   rxv   rxd    txr   we    chk   din    txv
    vecs[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{32'h0003_0000, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{32'h0003_0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{32'h0003_0000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[6]  = '{32'h0000_0020, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[7]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[11] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{32'h0003_0008, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{32'h0000_0030, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{32'h0000_0030, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[16] = '{32'h0003_0000, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[18] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0};
    vecs[19] = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};

    idle_inputs();
    rst_in = 1'b1;
    #2;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      v = vecs[i];
      mem_a = v.a; mem_wr = v.wr; mem_dout = v.dout; cpu_rdy = v.rdy;
      rx_valid = v.rxv; rx_data = v.rxd; tx_ready = v.txr;
      #1;
      chk($sformatf("v%0d_ram_we", i), {31'h0, ram_we}, {31'h0, v.exp_we});
      @(posedge clk_in); #1;
      if (v.chk_din) chk($sformatf("v%0d_mem_din", i), {24'h0, mem_din}, {24'h0, v.exp_din});
      chk($sformatf("v%0d_tx_valid", i), {31'h0, tx_valid}, {31'h0, v.exp_txv});
      chk($sformatf("v%0d_full", i), {31'h0, io_buffer_full}, 32'h0);
      chk($sformatf("v%0d_ovf", i), {31'h0, tx_overflow}, 32'h0);
      chk($sformatf("v%0d_done", i), {31'h0, program_done}, 32'h0);
    end
    idle_inputs();
    chk("tx_seen_count", tx_seen.size(), 32'd2);
    chk("tx_seen_0", {24'h0, tx_seen[0]}, 32'h41);
    chk("tx_seen_1", {24'h0, tx_seen[1]}, 32'h42);

    // Fill TX with the transmitter stalled: nearly-full at 14, drop at 17.
    for (int k = 1; k <= 17; k++) begin
      bus(32'h0003_0000, 1'b1, 8'(k), 1'b0);
      chk($sformatf("fill%0d_full", k), {31'h0, io_buffer_full}, {31'h0, (k >= 14)});
      chk($sformatf("fill%0d_ovf", k), {31'h0, tx_overflow}, {31'h0, (k >= 17)});
      chk($sformatf("fill%0d_tx_valid", k), {31'h0, tx_valid}, 32'h1);
    end

    do_reset();
    for (int k = 1; k <= 16; k++) begin
      bus(32'h0003_0000, 1'b1, 8'(k + 16), 1'b0);
      chk($sformatf("refill%0d_ovf", k), {31'h0, tx_overflow}, 32'h0);
    end
    chk("refill_full", {31'h0, io_buffer_full}, 32'h1);
    chk("refill_head", {24'h0, tx_data}, 32'h11);
    // Push onto a full queue while the head drains: accepted, no overflow.
    bus(32'h0003_0000, 1'b1, 8'hEE, 1'b1);
    chk("swap_ovf", {31'h0, tx_overflow}, 32'h0);
    chk("swap_full", {31'h0, io_buffer_full}, 32'h1);
    chk("swap_head", {24'h0, tx_data}, 32'h12);
    bus(32'h0003_0004, 1'b1, 8'h5A, 1'b0);
    chk("stop_done", {31'h0, program_done}, 32'h1);
    chk("stop_ovf", {31'h0, tx_overflow}, 32'h1);
    chk("stop_tx_valid", {31'h0, tx_valid}, 32'h1);
    bus(32'h0000_0000, 1'b0, 8'h00, 1'b0);
    chk("stop_sticky", {31'h0, program_done}, 32'h1);

    // Reset with done/overflow/full/valid all set, then the counter snapshot.
    do_reset();
    guard = 0;
    while (tb_cnt != 32'h0000_00FE && guard < 1000) begin
      @(posedge clk_in); #1;
      guard++;
    end
    chk("cnt_wait_timeout", {31'h0, (guard >= 1000)}, 32'h0);
    snap = tb_cnt;
    bus(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    chk("snap_b0", {24'h0, mem_din}, {24'h0, snap[7:0]});
    bus(32'h0000_0000, 1'b0, 8'h00, 1'b0);
    bus(32'h0003_0005, 1'b0, 8'h00, 1'b0);
    chk("snap_b1", {24'h0, mem_din}, {24'h0, snap[15:8]});
    bus(32'h0003_0006, 1'b0, 8'h00, 1'b0);
    chk("snap_b2", {24'h0, mem_din}, {24'h0, snap[23:16]});
    bus(32'h0003_0007, 1'b0, 8'h00, 1'b0);
    chk("snap_b3", {24'h0, mem_din}, {24'h0, snap[31:24]});
    snap = tb_cnt;
    bus(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    chk("resnap_b0", {24'h0, mem_din}, {24'h0, snap[7:0]});
    bus(32'h0003_0005, 1'b0, 8'h00, 1'b0);
    chk("resnap_b1", {24'h0, mem_din}, {24'h0, snap[15:8]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
